genie_split_bcast: RTL and testbench

Broadcast split node with per-output handshakes. It fans one upstream stream out to up to NO downstream branches, which are typically reconverged by a merge node. Each beat carries a destination mask. The beat is held until every selected branch has accepted it, and branches that have already taken it are not offered it again. Optional per-packet mask locking keeps every beat of a packet on the same branch set.

---
 rtl/genie_split_bcast.sv | 98 +++++++++
 tb/tb_genie_split_bcast.sv | 134 +++++++++++++
 2 files changed

// File: rtl/genie_split_bcast.sv
// Broadcast split: one upstream beat fans out to the outputs selected by its mask and is held until each selected output has taken it once.
// Define GENIE_SPLIT_MASK_LOCK_EN to reuse the first beat's mask for every beat of a packet.
module genie_split_bcast_lane (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic en,
  input  logic rdy,
  input  logic eop,
  input  logic clr,
  output logic o_valid,
  output logic o_eop,
  output logic ok
);
  logic done_q, done_d, fire;

  assign o_valid = reset & vld & en & ~done_q;
  assign fire    = o_valid & rdy;
  assign o_eop   = o_valid & eop;
  assign ok      = done_q | fire | ~en;

  always_comb begin
    done_d = done_q;
    if (clr)      done_d = 1'b0;
    else if (vld) done_d = done_q | fire;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) done_q <= 1'b0;
    else        done_q <= done_d;
endmodule

module genie_split_bcast #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(WIDTH>0 ? WIDTH : 1)-1:0]  i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_eop,
  input  logic [NO-1:0]                     i_mask,
  output logic [NO-1:0]                     o_valid,
  output logic [(WIDTH>0 ? WIDTH : 1)-1:0]  o_data,
  output logic [NO-1:0]                     o_eop,
  input  logic [NO-1:0]                     i_ready
);
  if (NO < 2) begin : g_bad_no
    $error("genie_split_bcast: NO must be >= 2");
  end

  logic [NO-1:0] emask, lane_ok;
  logic          in_pkt_q, in_pkt_d;

  assign o_data  = i_data;
  assign o_ready = reset & i_valid & (&lane_ok);

`ifdef GENIE_SPLIT_MASK_LOCK_EN
  logic [NO-1:0] lmask_q, lmask_d;

  assign emask = in_pkt_q ? lmask_q : i_mask;

  always_comb begin
    lmask_d = lmask_q;
    if (o_ready && !in_pkt_q) lmask_d = emask;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) lmask_q <= '0;
    else        lmask_q <= lmask_d;
`else
  assign emask = i_mask;
`endif

  // Packet state follows consumed beats, including ones dropped by an empty mask.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (o_ready) in_pkt_d = ~i_eop;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) in_pkt_q <= 1'b0;
    else        in_pkt_q <= in_pkt_d;

  genie_split_bcast_lane u_lane [NO-1:0] (
    .clk     (clk),
    .reset   (reset),
    .vld     (i_valid),
    .en      (emask),
    .rdy     (i_ready),
    .eop     (i_eop),
    .clr     (o_ready),
    .o_valid (o_valid),
    .o_eop   (o_eop),
    .ok      (lane_ok)
  );
endmodule

// File: tb/tb_genie_split_bcast.sv
// Directed bench for genie_split_bcast (NO=3, WIDTH=8); expectations adapt to GENIE_SPLIT_MASK_LOCK_EN.
module tb_genie_split_bcast;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       i_eop = 1'b0;
  logic [2:0] i_mask = '0;
  logic [2:0] o_valid;
  logic [7:0] o_data;
  logic [2:0] o_eop;
  logic [2:0] i_ready = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genie_split_bcast #(.NO(3), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_eop(i_eop), .i_mask(i_mask), .o_valid(o_valid), .o_data(o_data),
    .o_eop(o_eop), .i_ready(i_ready)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [2:0] m, input logic [2:0] r,
                       input logic e, input logic [7:0] d);
    @(negedge clk);
    i_valid = v; i_mask = m; i_ready = r; i_eop = e; i_data = d;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 3'b111, 3'b111, 1'b1, 8'h3C);
    checks++; if (o_valid !== 3'b000) begin errors++; $display("FAIL rst_valid got %b exp 000", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", o_ready); end
    checks++; if (o_eop !== 3'b000) begin errors++; $display("FAIL rst_eop got %b exp 000", o_eop); end
    checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL rst_data got %h exp 3c", o_data); end
    drive(1'b0, 3'b000, 3'b000, 1'b0, 8'h00);
    reset = 1'b1;
  endtask

  task automatic test_broadcast;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'hA5 + 8'(i);
      drive(1'b1, 3'b111, 3'b111, 1'(i == 3), d);
      checks++; if (o_valid !== 3'b111) begin errors++; $display("FAIL bcast_valid[%0d] got %b exp 111", i, o_valid); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready[%0d] got %b exp 1", i, o_ready); end
      checks++; if (o_data !== d) begin errors++; $display("FAIL bcast_data[%0d] got %h exp %h", i, o_data, d); end
    end
    checks++; if (o_eop !== 3'b111) begin errors++; $display("FAIL bcast_eop got %b exp 111", o_eop); end
  endtask

  task automatic test_stagger;
    drive(1'b1, 3'b111, 3'b001, 1'b1, 8'h11);
    checks++; if (o_valid !== 3'b111) begin errors++; $display("FAIL stag_valid0 got %b exp 111", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stag_ready0 got %b exp 0", o_ready); end
    drive(1'b1, 3'b111, 3'b100, 1'b1, 8'h11);
    checks++; if (o_valid !== 3'b110) begin errors++; $display("FAIL stag_valid1 got %b exp 110", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stag_ready1 got %b exp 0", o_ready); end
    drive(1'b1, 3'b111, 3'b010, 1'b1, 8'h11);
    checks++; if (o_valid !== 3'b010) begin errors++; $display("FAIL stag_valid2 got %b exp 010", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stag_ready2 got %b exp 1", o_ready); end
    checks++; if (o_eop !== 3'b010) begin errors++; $display("FAIL stag_eop2 got %b exp 010", o_eop); end
    // Next beat must be offered fresh to all outputs.
    drive(1'b1, 3'b111, 3'b000, 1'b1, 8'h12);
    checks++; if (o_valid !== 3'b111) begin errors++; $display("FAIL stag_next got %b exp 111", o_valid); end
    drive(1'b1, 3'b111, 3'b111, 1'b1, 8'h12);
    drive(1'b0, 3'b111, 3'b111, 1'b1, 8'h00);
    checks++; if (o_valid !== 3'b000) begin errors++; $display("FAIL stag_idle got %b exp 000", o_valid); end
  endtask

  task automatic test_empty;
    drive(1'b1, 3'b000, 3'b000, 1'b1, 8'h77);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %b exp 1", o_ready); end
    checks++; if (o_valid !== 3'b000) begin errors++; $display("FAIL empty_valid got %b exp 000", o_valid); end
    checks++; if (o_eop !== 3'b000) begin errors++; $display("FAIL empty_eop got %b exp 000", o_eop); end
    drive(1'b1, 3'b101, 3'b000, 1'b1, 8'h78);
    checks++; if (o_valid !== 3'b101) begin errors++; $display("FAIL empty_after got %b exp 101", o_valid); end
    drive(1'b1, 3'b101, 3'b101, 1'b1, 8'h78);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL empty_after_rdy got %b exp 1", o_ready); end
  endtask

  task automatic test_lock;
    logic [2:0] mid;
`ifdef GENIE_SPLIT_MASK_LOCK_EN
    mid = 3'b010;
`else
    mid = 3'b101;
`endif
    drive(1'b1, 3'b010, 3'b111, 1'b0, 8'h01);
    checks++; if (o_valid !== 3'b010) begin errors++; $display("FAIL lock_b1 got %b exp 010", o_valid); end
    drive(1'b1, 3'b101, 3'b111, 1'b0, 8'h02);
    checks++; if (o_valid !== mid) begin errors++; $display("FAIL lock_b2 got %b exp %b", o_valid, mid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL lock_b2_rdy got %b exp 1", o_ready); end
    drive(1'b1, 3'b101, 3'b111, 1'b1, 8'h03);
    checks++; if (o_valid !== mid) begin errors++; $display("FAIL lock_b3 got %b exp %b", o_valid, mid); end
    checks++; if (o_eop !== mid) begin errors++; $display("FAIL lock_b3_eop got %b exp %b", o_eop, mid); end
    drive(1'b1, 3'b101, 3'b111, 1'b1, 8'h04);
    checks++; if (o_valid !== 3'b101) begin errors++; $display("FAIL lock_next got %b exp 101", o_valid); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 3'b011, 3'b001, 1'b1, 8'h55);
    checks++; if (o_valid !== 3'b011) begin errors++; $display("FAIL rmid_v0 got %b exp 011", o_valid); end
    drive(1'b1, 3'b011, 3'b000, 1'b1, 8'h55);
    checks++; if (o_valid !== 3'b010) begin errors++; $display("FAIL rmid_v1 got %b exp 010", o_valid); end
    reset = 1'b0;
    #1;
    checks++; if (o_valid !== 3'b000) begin errors++; $display("FAIL rmid_rst_valid got %b exp 000", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rmid_rst_ready got %b exp 0", o_ready); end
    drive(1'b1, 3'b011, 3'b011, 1'b1, 8'h55);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rmid_rst_ready2 got %b exp 0", o_ready); end
    reset = 1'b1;
    drive(1'b1, 3'b011, 3'b000, 1'b1, 8'h55);
    checks++; if (o_valid !== 3'b011) begin errors++; $display("FAIL rmid_after got %b exp 011", o_valid); end
    drive(1'b1, 3'b011, 3'b011, 1'b1, 8'h55);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_after_rdy got %b exp 1", o_ready); end
    drive(1'b0, 3'b000, 3'b000, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset;
    test_broadcast;
    test_stagger;
    test_empty;
    test_lock;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
